// File: rtl/fb_pkg.sv
// Shared definitions for the frame-store manager: FSM encoding, buffer
// address helper and the buffer-count legality check.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRIPLE = 2'd1,
        ST_DOUBLE = 2'd2
    } fb_state_t;

    localparam int NUM_BUF_MIN = 2;
    localparam int NUM_BUF_MAX = 4;

    function automatic logic num_buf_legal(input int n);
        return (n >= NUM_BUF_MIN) && (n <= NUM_BUF_MAX);
    endfunction

    // Computed at 64 bits; callers truncate to their own address width.
    function automatic logic [63:0] buf_addr(input logic [63:0] base,
                                             input logic [63:0] stride,
                                             input logic [63:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/fb_free_picker.sv
// Returns the lowest buffer index whose busy bit is clear.
module fb_free_picker #(
    parameter int NUM_BUF = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_BUF-1:0] busy,
    output logic [IDX_W-1:0]   free_idx,
    output logic               none_free
);

    // Scan from the top down so the last hit is the lowest free index.
    always_comb begin
        free_idx  = '0;
        none_free = 1'b1;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx  = IDX_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_buf_manager.sv
// N-buffer frame-store manager: hands buffer indices/base addresses to the
// camera writer and HDMI reader in double or triple buffering mode.
module frame_buf_manager
    import fb_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0100_0000,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 32'h0010_0000,
    parameter int                NUM_BUF      = 3,
    parameter int                IDX_W        = 2,
    parameter int                CNT_W        = 16
) (
    input  logic              clk_100Mhz,
    input  logic              rst,
    input  logic              cfg_triple,
    input  logic              writer_done,
    input  logic              vsync_in,
    input  logic              cnt_clr,
    output logic [IDX_W-1:0]  w_idx,
    output logic [IDX_W-1:0]  r_idx,
    output logic [ADDR_W-1:0] w_base_addr,
    output logic [ADDR_W-1:0] r_base_addr,
    output logic              w_hold,
    output logic              frame_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt
);

    localparam logic             TRIPLE_OK = (NUM_BUF >= 3);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
        return ADDR_W'(buf_addr(64'(BASE_ADDR), 64'(FRAME_STRIDE), 64'(idx)));
    endfunction

    fb_state_t        state_reg, state_next;
    logic             cfg_d_reg, vsync_d_reg;
    logic [IDX_W-1:0] rdy_idx_reg, rdy_idx_next;
    logic [IDX_W-1:0] w_idx_next, r_idx_next;
    logic             rdy_valid_next, w_hold_next;
    logic             drop_inc, rep_inc;
    logic             eff_triple, vs, wd, cfg_change;
    logic [IDX_W-1:0] rst_r_idx;
    logic [NUM_BUF-1:0] busy_mask;
    logic [IDX_W-1:0] free_idx;
    logic             none_free;

    assign eff_triple = cfg_triple & TRIPLE_OK;
    assign rst_r_idx  = eff_triple ? IDX_W'(NUM_BUF - 1) : IDX_W'(1);
    assign vs         = vsync_in & ~vsync_d_reg;
    assign wd         = writer_done;
    assign cfg_change = cfg_triple ^ cfg_d_reg;

    // The reader's buffer is only free to reuse when it is being released this cycle.
    generate
        for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_busy
            assign busy_mask[gi] = (w_idx == IDX_W'(gi)) | (!vs && (r_idx == IDX_W'(gi)));
        end
    endgenerate

    fb_free_picker #(
        .NUM_BUF (NUM_BUF),
        .IDX_W   (IDX_W)
    ) u_picker (
        .busy      (busy_mask),
        .free_idx  (free_idx),
        .none_free (none_free)
    );

    always_comb begin
        state_next     = state_reg;
        w_idx_next     = w_idx;
        r_idx_next     = r_idx;
        rdy_idx_next   = rdy_idx_reg;
        rdy_valid_next = frame_ready;
        w_hold_next    = w_hold;
        drop_inc       = 1'b0;
        rep_inc        = 1'b0;
        case (state_reg)
            ST_INIT: begin
                w_idx_next     = '0;
                r_idx_next     = rst_r_idx;
                rdy_valid_next = 1'b0;
                w_hold_next    = 1'b0;
                state_next     = eff_triple ? ST_TRIPLE : ST_DOUBLE;
            end
            ST_TRIPLE: begin
                w_hold_next = 1'b0;
                if (cfg_change) begin
                    state_next = ST_INIT;
                end else if (wd && vs) begin
                    // The just-finished frame goes straight to the reader.
                    r_idx_next     = w_idx;
                    drop_inc       = frame_ready;
                    rdy_valid_next = 1'b0;
                    w_idx_next     = free_idx;
                end else if (wd) begin
                    drop_inc       = frame_ready;
                    rdy_idx_next   = w_idx;
                    rdy_valid_next = 1'b1;
                    w_idx_next     = free_idx;
                end else if (vs) begin
                    if (frame_ready) begin
                        r_idx_next     = rdy_idx_reg;
                        rdy_valid_next = 1'b0;
                    end else begin
                        rep_inc = 1'b1;
                    end
                end
            end
            ST_DOUBLE: begin
                if (cfg_change) begin
                    state_next = ST_INIT;
                end else begin
                    if (wd && frame_ready) begin
                        drop_inc = 1'b1;
                    end else if (wd && !vs) begin
                        rdy_valid_next = 1'b1;
                        w_hold_next    = 1'b1;
                    end
                    if (vs && (frame_ready || wd)) begin
                        w_idx_next     = r_idx;
                        r_idx_next     = w_idx;
                        rdy_valid_next = 1'b0;
                        w_hold_next    = 1'b0;
                    end else if (vs) begin
                        rep_inc = 1'b1;
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // The reader index reset value tracks the mode pin so the outputs are
    // already correct while rst is held.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_INIT;
            cfg_d_reg   <= 1'b0;
            vsync_d_reg <= 1'b0;
            rdy_idx_reg <= '0;
            w_idx       <= '0;
            r_idx       <= rst_r_idx;
            w_base_addr <= addr_of('0);
            r_base_addr <= addr_of(rst_r_idx);
            w_hold      <= 1'b0;
            frame_ready <= 1'b0;
            drop_cnt    <= '0;
            repeat_cnt  <= '0;
        end else begin
            state_reg   <= state_next;
            cfg_d_reg   <= cfg_triple;
            vsync_d_reg <= vsync_in;
            rdy_idx_reg <= rdy_idx_next;
            w_idx       <= w_idx_next;
            r_idx       <= r_idx_next;
            w_base_addr <= addr_of(w_idx_next);
            r_base_addr <= addr_of(r_idx_next);
            w_hold      <= w_hold_next;
            frame_ready <= rdy_valid_next;
            if (cnt_clr) begin
                drop_cnt <= '0;
            end else if (drop_inc && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (cnt_clr) begin
                repeat_cnt <= '0;
            end else if (rep_inc && (repeat_cnt != CNT_MAX)) begin
                repeat_cnt <= repeat_cnt + CNT_W'(1);
            end
        end
    end

    always @(posedge clk_100Mhz) begin
        if (!rst) begin
            assert (num_buf_legal(NUM_BUF) && (NUM_BUF <= (1 << IDX_W)))
                else $error("frame_buf_manager: illegal NUM_BUF/IDX_W");
            assert (w_idx != r_idx)
                else $error("frame_buf_manager: writer and reader share a buffer");
            assert (!(state_reg == ST_TRIPLE && frame_ready &&
                      (rdy_idx_reg == w_idx || rdy_idx_reg == r_idx)))
                else $error("frame_buf_manager: ready buffer collides with w/r");
            assert (!(state_reg == ST_TRIPLE && none_free))
                else $error("frame_buf_manager: no free buffer in triple mode");
        end
    end

endmodule
